// File: rtl/fp_rsp_skid_buffer.sv
// Two-entry elastic buffer between the FP square-root core and the commit arbiter.
// Optional stall counter output enabled by defining FP_RSP_SKID_PERF_EN.
module fp_rsp_skid_buffer #(
    parameter int TAGW  = 1,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [LANES*32-1:0]  result_in,
    input  logic                 has_fflags_in,
    input  logic [LANES*5-1:0]   fflags_in,
    input  logic [TAGW-1:0]      tag_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [LANES*32-1:0]  result_out,
    output logic                 has_fflags_out,
    output logic [LANES*5-1:0]   fflags_out,
`ifdef FP_RSP_SKID_PERF_EN
    output logic [TAGW-1:0]      tag_out,
    output logic [31:0]          perf_stall_cycles
`else
    output logic [TAGW-1:0]      tag_out
`endif
);

    localparam int PW = LANES*32 + 1 + LANES*5 + TAGW;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   in_pl;
    logic            in_fire;
    logic            out_fire;

    assign in_pl    = {result_in, has_fflags_in, fflags_in, tag_in};
    assign in_fire  = valid_in & ready_in;
    assign out_fire = valid_out & ready_out;

    assign {result_out, has_fflags_out, fflags_out, tag_out} = main_q;

    // valid_out and ready_in are flops so ready_in never sees ready_out combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q    <= in_pl;
                        valid_out <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_pl;
                    end else if (in_fire) begin
                        skid_q   <= in_pl;
                        ready_in <= 1'b0;
                        state    <= FULL;
                    end else if (out_fire) begin
                        valid_out <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_q   <= skid_q;
                        ready_in <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    ready_in  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef FP_RSP_SKID_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
        end else if (valid_out && !ready_out) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_rsp_skid_buffer.sv
// Self-checking bench for fp_rsp_skid_buffer (LANES=4, TAGW=4), queue-based reference model.
// Stall counter checks are active when FP_RSP_SKID_PERF_EN is defined.
module tb_fp_rsp_skid_buffer;

    localparam int TAGW  = 4;
    localparam int LANES = 4;

    logic                 clk;
    logic                 reset;
    logic                 valid_in;
    logic                 ready_in;
    logic [LANES*32-1:0]  result_in;
    logic                 has_fflags_in;
    logic [LANES*5-1:0]   fflags_in;
    logic [TAGW-1:0]      tag_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [LANES*32-1:0]  result_out;
    logic                 has_fflags_out;
    logic [LANES*5-1:0]   fflags_out;
    logic [TAGW-1:0]      tag_out;
`ifdef FP_RSP_SKID_PERF_EN
    logic [31:0]          perf_stall_cycles;
`endif

    fp_rsp_skid_buffer #(.TAGW(TAGW), .LANES(LANES)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .result_in      (result_in),
        .has_fflags_in  (has_fflags_in),
        .fflags_in      (fflags_in),
        .tag_in         (tag_in),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .result_out     (result_out),
        .has_fflags_out (has_fflags_out),
        .fflags_out     (fflags_out),
`ifdef FP_RSP_SKID_PERF_EN
        .tag_out        (tag_out),
        .perf_stall_cycles (perf_stall_cycles)
`else
        .tag_out        (tag_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*32-1:0] res;
        logic                hf;
        logic [LANES*5-1:0]  ff;
        logic [TAGW-1:0]     tag;
    } pl_t;

    // Reference: a FIFO of capacity two; accept when it held fewer than two entries.
    pl_t         mq[$];
    logic [31:0] m_perf;
    int          n_checks = 0;
    int          n_pass   = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_perf = 32'd0;
        end else begin
            automatic bit acc  = valid_in && (mq.size() < 2);
            automatic bit take = (mq.size() > 0) && ready_out;
            automatic pl_t p;
            p.res = result_in; p.hf = has_fflags_in; p.ff = fflags_in; p.tag = tag_in;
            if (mq.size() > 0 && !ready_out) m_perf = m_perf + 32'd1;
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(p);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_valid_out", {127'd0, valid_out}, {127'd0, mq.size() > 0});
        chk("model_ready_in", {127'd0, ready_in}, {127'd0, mq.size() < 2});
        if (mq.size() > 0) begin
            chk("model_result", result_out, mq[0].res);
            chk("model_hf", {127'd0, has_fflags_out}, {127'd0, mq[0].hf});
            chk("model_ff", {108'd0, fflags_out}, {108'd0, mq[0].ff});
            chk("model_tag", {124'd0, tag_out}, {124'd0, mq[0].tag});
        end
`ifdef FP_RSP_SKID_PERF_EN
        chk("model_perf", {96'd0, perf_stall_cycles}, {96'd0, m_perf});
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TAGW-1:0] t, input logic [31:0] r,
                         input logic hf, input logic [4:0] ff);
        valid_in      = v;
        tag_in        = t;
        result_in     = {LANES{r}};
        has_fflags_in = hf;
        fflags_in     = {LANES{ff}};
    endtask

    initial begin
        reset = 1'b1;
        ready_out = 1'b0;
        drive(1'b1, 4'd0, 32'h3F800000, 1'b0, 5'd0);

        // Reset held with valid_in active.
        step(); step();
        chk("rst_valid_out", {127'd0, valid_out}, 128'd0);
        chk("rst_ready_in", {127'd0, ready_in}, 128'd1);
        chk("rst_tag_out", {124'd0, tag_out}, 128'd0);
        reset = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        step(); step();
        chk("post_rst_idle", {127'd0, valid_out}, 128'd0);

        // Streaming with ready_out high.
        ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 32'h40000000 + 32'(i), 1'b0, 5'd0);
            step();
            chk("stream_tag", {124'd0, tag_out}, 128'(i));
            chk("stream_res", result_out, {4{32'h40000000 + 32'(i)}});
            chk("stream_ready", {127'd0, ready_in}, 128'd1);
        end
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        step();
        chk("stream_drain", {127'd0, valid_out}, 128'd0);

        // Skid fill and third request rejected.
        ready_out = 1'b0;
        drive(1'b1, 4'd1, 32'h1, 1'b0, 5'd0);
        step();
        drive(1'b1, 4'd2, 32'h2, 1'b0, 5'd0);
        step();
        chk("skid_ready_low", {127'd0, ready_in}, 128'd0);
        chk("skid_tag1", {124'd0, tag_out}, 128'd1);
        drive(1'b1, 4'd3, 32'h3, 1'b0, 5'd0);
        step(); step();
        chk("skid_hold_tag1", {124'd0, tag_out}, 128'd1);
        chk("skid_still_full", {127'd0, ready_in}, 128'd0);
        ready_out = 1'b1;
        step();
        chk("skid_tag2", {124'd0, tag_out}, 128'd2);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        chk("skid_tag3", {124'd0, tag_out}, 128'd3);
        step();
        chk("skid_empty", {127'd0, valid_out}, 128'd0);

        // Simultaneous in/out while ONE.
        ready_out = 1'b0;
        drive(1'b1, 4'd5, 32'h5, 1'b0, 5'd0);
        step();
        chk("sim_tag5", {124'd0, tag_out}, 128'd5);
        drive(1'b1, 4'd6, 32'h6, 1'b0, 5'd0);
        ready_out = 1'b1;
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        chk("sim_tag6", {124'd0, tag_out}, 128'd6);
        chk("sim_no_bubble", {127'd0, valid_out}, 128'd1);
        step();

        // Payload integrity across stall and release.
        ready_out = 1'b0;
        drive(1'b1, 4'd9, 32'h7FC00000, 1'b1, 5'b10000);
        step();
        drive(1'b1, 4'd10, 32'h00000000, 1'b0, 5'b00000);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        step(); step(); step();
        chk("pl_result", result_out, {4{32'h7FC00000}});
        chk("pl_hf", {127'd0, has_fflags_out}, 128'd1);
        chk("pl_ff", {108'd0, fflags_out}, 128'h84210);
        ready_out = 1'b1;
        step();
        chk("pl2_tag", {124'd0, tag_out}, 128'd10);
        chk("pl2_hf", {127'd0, has_fflags_out}, 128'd0);
        step();

        // Stall counting, then reset while FULL.
        #1 reset = 1'b1;
        step();
        reset = 1'b0;
        ready_out = 1'b0;
        drive(1'b1, 4'd1, 32'h11, 1'b0, 5'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) step();
`ifdef FP_RSP_SKID_PERF_EN
        chk("perf_10", {96'd0, perf_stall_cycles}, 128'd10);
`endif
        drive(1'b1, 4'd2, 32'h22, 1'b0, 5'd0);
        step();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 5'd0);
        chk("full_before_rst", {127'd0, ready_in}, 128'd0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", {127'd0, valid_out}, 128'd0);
        chk("midrst_ready", {127'd0, ready_in}, 128'd1);
`ifdef FP_RSP_SKID_PERF_EN
        chk("midrst_perf", {96'd0, perf_stall_cycles}, 128'd0);
`endif
        step();
        reset = 1'b0;
        ready_out = 1'b1;
        step(); step(); step();
        chk("no_stale", {127'd0, valid_out}, 128'd0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
